// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage program-counter unit.
package pc_pkg;

  localparam int unsigned PC_STEP              = 4;
  localparam int          DEFAULT_WIDTH        = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_RAS_DEPTH    = 4;

  // Which source feeds the PC register on the next edge.
  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_REDIRECT,
    SRC_HOLD,
    SRC_RAS,
    SRC_SEQ
  } next_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular-buffer return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] stack_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W:0]   count_reg;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W + 1)'(RAS_DEPTH));
  // ptr_reg names the next free slot, so the top lives one below it.
  assign top   = stack_mem[ptr_reg - PTR_W'(1)];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg   <= ptr_reg + PTR_W'(1);
      count_reg <= full ? count_reg : count_reg + (PTR_W + 1)'(1);
    end else if (pop && !empty) begin
      ptr_reg   <= ptr_reg - PTR_W'(1);
      count_reg <= count_reg - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      stack_mem[ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, stall and optional return-address stack.
// Define PC_RAS_EN to build the return-address stack; otherwise call/ret are inert.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ret_miss,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ret_miss_reg;
  logic             ret_miss_next;
  logic             misalign_reg;
  next_src_e        src;

  assign pc_out   = pc_reg;
  assign pc_plus4 = pc_reg + WIDTH'(PC_STEP);
  assign ret_miss = ret_miss_reg;
  assign misalign = misalign_reg;

  always_comb begin
    src = SRC_SEQ;
    if (reset)                   src = SRC_RESET;
    else if (redirect_valid)     src = SRC_REDIRECT;
    else if (stall)              src = SRC_HOLD;
    else if (ret && !ras_empty)  src = SRC_RAS;
  end

  always_comb begin
    pc_next = pc_plus4;
    case (src)
      SRC_RESET:    pc_next = RESET_VECTOR;
      SRC_REDIRECT: pc_next = {redirect_target[WIDTH-1:2], 2'b00};
      SRC_HOLD:     pc_next = pc_reg;
      SRC_RAS:      pc_next = ras_top;
      default:      pc_next = pc_plus4;
    endcase
  end

`ifdef PC_RAS_EN
  logic ras_push;
  logic ras_pop;
  logic ras_full;
  logic unused_ras_full;

  // The return address is the instruction after the call itself.
  assign ras_push        = redirect_valid && call && !reset;
  assign ras_pop         = (src == SRC_RAS);
  assign ret_miss_next   = ret && !redirect_valid && !stall && ras_empty;
  assign unused_ras_full = ras_full;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  logic unused_call;

  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ret_miss_next = 1'b0;
  assign unused_call   = call;
`endif

  always_ff @(posedge clock) begin
    pc_reg <= pc_next;
    if (reset) begin
      ret_miss_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      ret_miss_reg <= ret_miss_next;
      // Sticky: a stalled redirect still reports its bad target.
      if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
        misalign_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven scoreboard bench for pc_unit; expectations follow the build's PC_RAS_EN setting.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ret_miss;
  logic        misalign;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .ras_empty       (ras_empty),
    .ret_miss        (ret_miss),
    .misalign        (misalign)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic        cl;
    logic        rt;
    logic [31:0] pc;
    logic        emp;
    logic        miss;
    logic        mis;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(input logic rst, input logic stl, input logic rv,
                              input logic [31:0] tgt, input logic cl, input logic rt,
                              input logic [31:0] pc, input logic emp, input logic miss,
                              input logic mis);
    vec_t v;
    v = '{rst, stl, rv, tgt, cl, rt, pc, emp, miss, mis};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, req);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    vec_t e;
    // rst stl rv  target        cl rt   pc             emp miss mis
    add(1, 0, 0, 32'h0,         0, 0, RV,            1, 0, 0);
    add(1, 0, 0, 32'h0,         0, 0, RV,            1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, RV + 32'h4,    1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, RV + 32'h8,    1, 0, 0);
    add(0, 0, 1, 32'h10,        0, 0, 32'h10,        1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h10,        1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h10,        1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h10,        1, 0, 0);
    add(0, 1, 1, 32'h80,        0, 0, 32'h80,        1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h84,        1, 0, 0);
    add(0, 0, 1, 32'h103,       0, 0, 32'h100,       1, 0, 1);
    add(0, 1, 0, 32'h0,         0, 0, 32'h100,       1, 0, 1);
    add(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 1);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 1);
    add(0, 0, 0, 32'h0,         0, 0, 32'h4,         1, 0, 1);
    add(1, 0, 0, 32'h0,         0, 0, RV,            1, 0, 0);
    add(0, 1, 1, 32'h202,       0, 0, 32'h200,       1, 0, 1);
    add(1, 0, 1, 32'h43,        0, 0, RV,            1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, RV + 32'h4,    1, 0, 0);
`ifdef PC_RAS_EN
    add(0, 0, 1, 32'h20,        0, 0, 32'h20,        1, 0, 0);
    add(0, 0, 1, 32'h100,       1, 0, 32'h100,       0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h104,       0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h24,        1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h28,        1, 0, 0);
    add(0, 0, 1, 32'h0,         0, 0, 32'h0,         1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      add(0, 0, 1, 32'(4 * i),  1, 0, 32'(4 * i),    0, 0, 0);
    end
    add(0, 0, 1, 32'h300,       0, 0, 32'h300,       0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h14,        0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h10,        0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'hC,         0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h8,         1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'hC,         1, 1, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h10,        1, 1, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h14,        1, 0, 0);
    add(0, 0, 1, 32'h40,        1, 0, 32'h40,        0, 0, 0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h40,        0, 0, 0);
    add(0, 0, 1, 32'h60,        0, 1, 32'h60,        0, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h64,        0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h18,        1, 0, 0);
    add(0, 0, 1, 32'h80,        1, 0, 32'h80,        0, 0, 0);
    add(1, 0, 0, 32'h0,         0, 1, RV,            1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, RV + 32'h4,    1, 1, 0);
    add(0, 0, 0, 32'h0,         0, 0, RV + 32'h8,    1, 0, 0);
    add(0, 1, 0, 32'h0,         0, 1, RV + 32'h8,    1, 0, 0);
`else
    add(0, 0, 1, 32'h20,        0, 0, 32'h20,        1, 0, 0);
    add(0, 0, 1, 32'h100,       1, 0, 32'h100,       1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h104,       1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h108,       1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h10C,       1, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h110,       1, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset           = vecs[i].rst;
      stall           = vecs[i].stl;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      call            = vecs[i].cl;
      ret             = vecs[i].rt;
      exp_q.push_back(vecs[i]);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      $display("vec %0d: rst=%0b stl=%0b rv=%0b tgt=%h call=%0b ret=%0b -> pc=%h plus4=%h empty=%0b miss=%0b misalign=%0b",
               i, e.rst, e.stl, e.rv, e.tgt, e.cl, e.rt, pc_out, pc_plus4, ras_empty,
               ret_miss, misalign);
      chk("pc_out",    i, pc_out,            e.pc);
      chk("pc_plus4",  i, pc_plus4,          e.pc + 32'h4);
      chk("ras_empty", i, 32'(ras_empty),    32'(e.emp));
      chk("ret_miss",  i, 32'(ret_miss),     32'(e.miss));
      chk("misalign",  i, 32'(misalign),     32'(e.mis));
    end

    chk("queue_drained", vecs.size(), 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
